dmem_ctrl: RTL and testbench

Data-memory access controller sitting between the DLX MEM stage and the `sram` model. It is the initiator side of the sram `cs/oe/we/addr/din/dout` interface. It accepts one load or store request at a time, sequences the sram control strobes with a configurable number of wait cycles, and performs big-endian sub-word extraction and sign/zero extension. Byte and halfword stores are done as read-modify-write.

---
 rtl/dmem_ctrl_if.sv | 32 +++
 rtl/dmem_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_if.sv
// Request/response and sram strobe bundle for dmem_ctrl.
// slave = controller view, master = MEM-stage/sram environment view.
interface dmem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [0:31] req_wdata;
    logic        resp_valid;
    logic [0:31] resp_rdata;
    logic        resp_err;
    logic        mem_cs;
    logic        mem_oe;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [0:31] mem_din;
    logic [0:31] mem_dout;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_dout,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_cs, mem_oe, mem_we, mem_addr, mem_din
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_dout,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_cs, mem_oe, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: sequences sram strobes, big-endian sub-word loads.
// Define DMEM_RMW_EN to enable byte/halfword stores via read-modify-write.
module dmem_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    dmem_ctrl_if.slave bus
);
    localparam logic [3:0] WLAST = 4'(WAIT_CYCLES - 1);

`ifdef DMEM_RMW_EN
    typedef enum logic [2:0] {IDLE, RD, MERGE, WR, RESP} state_e;
`else
    typedef enum logic [2:0] {IDLE, RD, WR, RESP} state_e;
`endif

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  off_q;
`ifdef DMEM_RMW_EN
    logic        we_q;
    logic [15:0] wlane_q;
    logic [0:31] old_q;
    logic [0:31] merge_d;
`endif
    logic        mem_cs_q, mem_oe_q, mem_we_q;
    logic [31:0] mem_addr_q;
    logic [0:31] mem_din_q;
    logic        resp_valid_q, resp_err_q;
    logic [0:31] resp_rdata_q;

    logic        req_err, sub_word;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [0:31] load_d;

    always_comb begin
        sub_word = (bus.req_size != 2'b10);
        req_err  = (bus.req_size == 2'b11)
                 || (bus.req_size == 2'b01 && bus.req_addr[0])
                 || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
`ifndef DMEM_RMW_EN
        req_err  = req_err || (bus.req_we && sub_word);
`endif
    end

    // Big-endian lanes: offset 0 is the most significant byte, bits [0:7].
    always_comb begin
        case (off_q)
            2'd0:    byte_v = bus.mem_dout[0:7];
            2'd1:    byte_v = bus.mem_dout[8:15];
            2'd2:    byte_v = bus.mem_dout[16:23];
            default: byte_v = bus.mem_dout[24:31];
        endcase
        half_v = off_q[1] ? bus.mem_dout[16:31] : bus.mem_dout[0:15];
        case (size_q)
            2'b00:   load_d = {{24{signed_q & byte_v[7]}}, byte_v};
            2'b01:   load_d = {{16{signed_q & half_v[15]}}, half_v};
            default: load_d = bus.mem_dout;
        endcase
    end

`ifdef DMEM_RMW_EN
    always_comb begin
        merge_d = old_q;
        if (size_q == 2'b00) begin
            case (off_q)
                2'd0:    merge_d[0:7]   = wlane_q[7:0];
                2'd1:    merge_d[8:15]  = wlane_q[7:0];
                2'd2:    merge_d[16:23] = wlane_q[7:0];
                default: merge_d[24:31] = wlane_q[7:0];
            endcase
        end else if (off_q[1]) begin
            merge_d[16:31] = wlane_q;
        end else begin
            merge_d[0:15] = wlane_q;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            off_q        <= '0;
`ifdef DMEM_RMW_EN
            we_q         <= 1'b0;
            wlane_q      <= '0;
            old_q        <= '0;
`endif
            mem_cs_q     <= 1'b0;
            mem_oe_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        size_q     <= bus.req_size;
                        signed_q   <= bus.req_signed;
                        off_q      <= bus.req_addr[1:0];
                        mem_addr_q <= {bus.req_addr[31:2], 2'b00};
                        cnt_q      <= WLAST;
`ifdef DMEM_RMW_EN
                        we_q       <= bus.req_we;
                        wlane_q    <= bus.req_wdata[16:31];
`endif
                        if (req_err) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else if (!bus.req_we || sub_word) begin
                            state_q  <= RD;
                            mem_cs_q <= 1'b1;
                            mem_oe_q <= 1'b1;
                        end else begin
                            state_q   <= WR;
                            mem_cs_q  <= 1'b1;
                            mem_we_q  <= 1'b1;
                            mem_din_q <= bus.req_wdata;
                        end
                    end
                end
                RD: begin
                    if (cnt_q == '0) begin
                        mem_cs_q <= 1'b0;
                        mem_oe_q <= 1'b0;
`ifdef DMEM_RMW_EN
                        if (we_q) begin
                            old_q   <= bus.mem_dout;
                            state_q <= MERGE;
                        end else
`endif
                        begin
                            resp_rdata_q <= load_d;
                            resp_valid_q <= 1'b1;
                            state_q      <= RESP;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
`ifdef DMEM_RMW_EN
                MERGE: begin
                    mem_din_q <= merge_d;
                    mem_cs_q  <= 1'b1;
                    mem_we_q  <= 1'b1;
                    cnt_q     <= WLAST;
                    state_q   <= WR;
                end
`endif
                WR: begin
                    if (cnt_q == '0) begin
                        mem_cs_q     <= 1'b0;
                        mem_we_q     <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.mem_cs     = mem_cs_q;
    assign bus.mem_oe     = mem_oe_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_din    = mem_din_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: one W=1 and one W=3 instance, each with a small sram model.
module tb_dmem_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, rst3, sel;
    logic        t_valid, t_we, t_signed;
    logic [1:0]  t_size;
    logic [31:0] t_addr;
    logic [0:31] t_wdata;
    logic        pre_en;
    logic [5:0]  pre_idx;
    logic [0:31] pre_data;
    logic [0:31] mem1 [0:63];
    logic [0:31] mem3 [0:63];
    int unsigned n_total = 0;
    int unsigned n_bad = 0;

    dmem_ctrl_if if1();
    dmem_ctrl_if if3();

    dmem_ctrl #(.WAIT_CYCLES(1)) u_dut1 (.clk_i(clk), .rst_i(rst1), .bus(if1.slave));
    dmem_ctrl #(.WAIT_CYCLES(3)) u_dut3 (.clk_i(clk), .rst_i(rst3), .bus(if3.slave));

    assign if1.req_valid  = t_valid & ~sel;
    assign if3.req_valid  = t_valid & sel;
    assign if1.req_we     = t_we;
    assign if3.req_we     = t_we;
    assign if1.req_size   = t_size;
    assign if3.req_size   = t_size;
    assign if1.req_signed = t_signed;
    assign if3.req_signed = t_signed;
    assign if1.req_addr   = t_addr;
    assign if3.req_addr   = t_addr;
    assign if1.req_wdata  = t_wdata;
    assign if3.req_wdata  = t_wdata;

    always @(posedge clk) begin
        if (pre_en) mem1[pre_idx] <= pre_data;
        else if (if1.mem_cs && if1.mem_we) mem1[if1.mem_addr[7:2]] <= if1.mem_din;
        if (if3.mem_cs && if3.mem_we) mem3[if3.mem_addr[7:2]] <= if3.mem_din;
    end
    assign if1.mem_dout = (if1.mem_cs && if1.mem_oe) ? mem1[if1.mem_addr[7:2]] : '0;
    assign if3.mem_dout = (if3.mem_cs && if3.mem_oe) ? mem3[if3.mem_addr[7:2]] : '0;

    logic        o_ready, o_cs, o_oe, o_we, o_valid, o_err;
    logic [31:0] o_addr, o_din, o_rdata;
    assign o_ready = sel ? if3.req_ready  : if1.req_ready;
    assign o_cs    = sel ? if3.mem_cs     : if1.mem_cs;
    assign o_oe    = sel ? if3.mem_oe     : if1.mem_oe;
    assign o_we    = sel ? if3.mem_we     : if1.mem_we;
    assign o_addr  = sel ? if3.mem_addr   : if1.mem_addr;
    assign o_din   = sel ? if3.mem_din    : if1.mem_din;
    assign o_valid = sel ? if3.resp_valid : if1.resp_valid;
    assign o_err   = sel ? if3.resp_err   : if1.resp_err;
    assign o_rdata = sel ? if3.resp_rdata : if1.resp_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issues one request and watches the bus until resp_valid (cycle 1 follows the accept edge).
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int unsigned cyc, output logic [31:0] rdata, output logic err,
                          output int unsigned nrd, output int unsigned nwr,
                          output logic [31:0] din, output logic [31:0] maddr, output logic bad_strobe);
        @(negedge clk);
        t_we = we; t_size = size; t_signed = sgn; t_addr = addr; t_wdata = wdata;
        t_valid = 1'b1;
        @(posedge clk);
        #1 t_valid = 1'b0;
        t_wdata = 32'h5555_AAAA;
        cyc = 0; nrd = 0; nwr = 0; din = '0; maddr = '0; bad_strobe = 1'b0; rdata = '0; err = 1'b0;
        for (int unsigned c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (o_cs && o_oe) nrd++;
            if (o_cs && o_we) begin nwr++; din = o_din; end
            if (o_cs) maddr = o_addr;
            if ((o_oe && o_we) || (!o_cs && (o_oe || o_we))) bad_strobe = 1'b1;
            if (o_valid) begin
                cyc = c; rdata = o_rdata; err = o_err;
                break;
            end
        end
    endtask

    task automatic ld(input string tag, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] exp);
        int unsigned cyc, nrd, nwr, w;
        logic [31:0] rdata, din, maddr;
        logic err, bs;
        w = sel ? 3 : 1;
        do_req(1'b0, size, sgn, addr, 32'h0, cyc, rdata, err, nrd, nwr, din, maddr, bs);
        check({tag, "_data"}, rdata, exp);
        check({tag, "_cyc"}, cyc, w + 1);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_nrd"}, nrd, w);
        check({tag, "_addr"}, maddr, {addr[31:2], 2'b00});
        check({tag, "_strb"}, {31'd0, bs} | nwr, 32'd0);
    endtask

    task automatic st(input string tag, input logic [1:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_din,
                      input int unsigned exp_cyc, input int unsigned exp_nrd, input int unsigned exp_nwr);
        int unsigned cyc, nrd, nwr;
        logic [31:0] rdata, din, maddr;
        logic err, bs;
        do_req(1'b1, size, 1'b0, addr, wdata, cyc, rdata, err, nrd, nwr, din, maddr, bs);
        check({tag, "_din"}, din, exp_din);
        check({tag, "_cyc"}, cyc, exp_cyc);
        check({tag, "_nrd"}, nrd, exp_nrd);
        check({tag, "_nwr"}, nwr, exp_nwr);
        check({tag, "_err_rd"}, {err, bs, 30'd0} | rdata, 32'd0);
    endtask

    task automatic er(input string tag, input logic we, input logic [1:0] size, input logic [31:0] addr);
        int unsigned cyc, nrd, nwr;
        logic [31:0] rdata, din, maddr;
        logic err, bs;
        do_req(we, size, 1'b1, addr, 32'hFFFF_FFFF, cyc, rdata, err, nrd, nwr, din, maddr, bs);
        check({tag, "_err"}, {31'd0, err}, 32'd1);
        check({tag, "_cyc"}, cyc, 32'd1);
        check({tag, "_rdata"}, rdata, 32'd0);
        check({tag, "_access"}, nrd + nwr + {31'd0, bs}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned vcount;
        sel = 1'b0; t_valid = 1'b0; t_we = 1'b0; t_signed = 1'b0; t_size = '0;
        t_addr = '0; t_wdata = '0; rst1 = 1'b1; rst3 = 1'b1;
        pre_en = 1'b0; pre_idx = '0; pre_data = '0;
        repeat (2) @(negedge clk);
        pre_en = 1'b1; pre_idx = 6'd32; pre_data = 32'hF0F0_F0F0;
        @(negedge clk);
        pre_idx = 6'd33; pre_data = 32'h1280_7F56;
        @(negedge clk);
        pre_en = 1'b0;

        check("rst_ready", {31'd0, o_ready}, 32'd1);
        check("rst_strobes", {29'd0, o_cs, o_oe, o_we}, 32'd0);
        check("rst_addr", o_addr, 32'd0);
        check("rst_din", o_din, 32'd0);
        check("rst_resp", {31'd0, o_valid} | {30'd0, o_err, 1'b0}, 32'd0);
        check("rst_rdata", o_rdata, 32'd0);
        rst1 = 1'b0; rst3 = 1'b0;

        ld("ldb_s80", 2'b00, 1'b1, 32'h80, 32'hFFFF_FFF0);
        ld("ldb_u81", 2'b00, 1'b0, 32'h81, 32'h0000_00F0);
        ld("ldh_s82", 2'b01, 1'b1, 32'h82, 32'hFFFF_F0F0);
        ld("ldw_80",  2'b10, 1'b0, 32'h80, 32'hF0F0_F0F0);
        ld("ldh_u84", 2'b01, 1'b0, 32'h84, 32'h0000_1280);
        ld("ldb_s85", 2'b00, 1'b1, 32'h85, 32'hFFFF_FF80);
        ld("ldb_u85", 2'b00, 1'b0, 32'h85, 32'h0000_0080);
        ld("ldb_s87", 2'b00, 1'b1, 32'h87, 32'h0000_0056);
        ld("ldh_s86", 2'b01, 1'b1, 32'h86, 32'h0000_7F56);

        er("err_ldw82", 1'b0, 2'b10, 32'h82);
        er("err_sth81", 1'b1, 2'b01, 32'h81);
        er("err_size3", 1'b0, 2'b11, 32'h80);

`ifdef DMEM_RMW_EN
        st("stb_83", 2'b00, 32'h83, 32'h0000_00AB, 32'hF0F0_F0AB, 4, 1, 1);
        ld("ldw_80b", 2'b10, 1'b0, 32'h80, 32'hF0F0_F0AB);
        st("sth_84", 2'b01, 32'h84, 32'hDEAD_BEEF, 32'hBEEF_7F56, 4, 1, 1);
        st("stb_84", 2'b00, 32'h84, 32'h1234_565A, 32'h5AEF_7F56, 4, 1, 1);
        ld("ldw_84", 2'b10, 1'b0, 32'h84, 32'h5AEF_7F56);
`else
        er("err_stb80", 1'b1, 2'b00, 32'h80);
        er("err_sth84", 1'b1, 2'b01, 32'h84);
        ld("ldw_80b", 2'b10, 1'b0, 32'h80, 32'hF0F0_F0F0);
`endif
        st("stw_88", 2'b10, 32'h88, 32'h1122_3344, 32'h1122_3344, 2, 0, 1);
        ld("ldw_88", 2'b10, 1'b0, 32'h88, 32'h1122_3344);

        sel = 1'b1;
        st("w3_stw_10", 2'b10, 32'h10, 32'h1234_5678, 32'h1234_5678, 4, 0, 3);
        ld("w3_ldw_10", 2'b10, 1'b0, 32'h10, 32'h1234_5678);
        ld("w3_ldb_11", 2'b00, 1'b1, 32'h11, 32'h0000_0034);

        @(negedge clk);
        t_we = 1'b1; t_size = 2'b10; t_addr = 32'h14; t_wdata = 32'hCAFE_BABE; t_valid = 1'b1;
        @(posedge clk);
        #1 t_valid = 1'b0;
        @(negedge clk);
        check("abort_wr1", {30'd0, o_cs, o_we}, 32'd3);
        @(negedge clk);
        rst3 = 1'b1;
        @(negedge clk);
        check("abort_strobes", {29'd0, o_cs, o_oe, o_we}, 32'd0);
        check("abort_ready", {31'd0, o_ready}, 32'd1);
        check("abort_valid", {31'd0, o_valid}, 32'd0);
        rst3 = 1'b0;
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (o_valid || o_cs) vcount++;
        end
        check("abort_quiet", vcount, 32'd0);

        rst3 = 1'b1;
        t_we = 1'b0; t_size = 2'b10; t_addr = 32'h10; t_valid = 1'b1;
        @(negedge clk);
        rst3 = 1'b0; t_valid = 1'b0;
        check("rstreq_ready", {31'd0, o_ready}, 32'd1);
        @(negedge clk);
        check("rstreq_idle", {30'd0, o_cs, ~o_ready}, 32'd0);
        ld("w3_ldw_10b", 2'b10, 1'b0, 32'h10, 32'h1234_5678);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
